dtc_fe_pingpong_framer: RTL
===========================

// Module: dtc_fe_pingpong_framer
// PURPOSE
//  Parametrised front-end emulator stage for the GBT uplink.
//  - Accepts N_CH CIC nibble streams through a valid/ready handshake.
//  - Double-buffers whole packets in two banks, so one bank is written while the other is read.
//  - Serialises each packet into per-channel e-port words, SER_RATIO nibbles per word.
//  - Packs the words into a 40 MHz-rate frame bus, one 40-bit slot per channel.
//  - Sits between the pattern-BRAM reader and the GBT TX frame mux.
// PARAMETERS
//  N_CH       2   number of CIC channels
//  NIB_W      4   bits per channel per CLK320 cycle
//  PKT_LEN    64  nibbles per packet; must be a multiple of SER_RATIO
//  SER_RATIO  8   nibbles per e-port word (CLK320/CLK40 ratio)
//  L1_W       8   zero-filled L1 bits appended per channel slot
// PORTS
//  CLK320     in   1                          single clock for the whole block
//  RESET      in   1                          asynchronous, active-high reset
//  IN_DATA    in   N_CH*NIB_W                 one nibble per channel; ch c is [c*NIB_W +: NIB_W]
//  IN_VALID   in   1                          IN_DATA is valid this cycle
//  IN_READY   out  1                          current write bank can accept data
//  DTC_FE_OUT out  N_CH*(SER_RATIO*NIB_W+L1_W) frame bus; ch c is [c*SLOT +: SLOT]
//  FRAME_STB  out  1                          1-cycle pulse when DTC_FE_OUT updates
//  FRAME_SOP  out  1                          with FRAME_STB: frame is the first word of a packet
//  STAT_DROP  out  16                         saturating count of IN_VALID && !IN_READY cycles
// BEHAVIOUR
//  Reset values
//  - All outputs 0 except IN_READY: it is 1 one cycle after RESET deasserts, 0 while RESET is high.
//  - Bank full flags 0; wr_bank = rd_bank = 0; all pointers and the phase counter 0; read FSM in IDLE.
//  Write side
//  - IN_READY = !full[wr_bank].
//  - On IN_VALID && IN_READY: write IN_DATA at wr_ptr in wr_bank, then increment wr_ptr.
//  - When wr_ptr == PKT_LEN-1 is written: wr_ptr <= 0, full[wr_bank] <= 1, wr_bank toggles.
//  - IN_VALID && !IN_READY: data is dropped and STAT_DROP increments, saturating at 16'hFFFF.
//  Phase counter
//  - phase runs freely 0..SER_RATIO-1 and wraps; it defines word boundaries.
//  Read FSM, states IDLE and SEND
//  - IDLE -> SEND when phase == 0 && full[rd_bank]; rd_ptr <= 0 and the pending-SOP flag is set.
//  - In IDLE the emitted nibble is the idle pattern (see CONFIGURATION).
//  - In SEND the nibble at rd_ptr of rd_bank is registered (1-cycle read) into the shifter.
//  - When rd_ptr == PKT_LEN-1 is read: full[rd_bank] <= 0, rd_bank toggles.
//    - Stay in SEND with rd_ptr <= 0 if the other bank is full: back-to-back packets, no gap.
//    - Otherwise go to IDLE.
//  - Packets start only at phase 0; because PKT_LEN is a multiple of SER_RATIO, packets never straddle words.
//  Framing
//  - Each channel has a shifter; the first nibble of a word lands in slot bits [31:28] (MSB-first).
//  - One cycle after the nibble of phase SER_RATIO-1 is captured:
//    - DTC_FE_OUT[c*SLOT +: 32] <= shifter c.
//    - DTC_FE_OUT[c*SLOT+32 +: L1_W] <= 0.
//    - FRAME_STB pulses.
//  - Latency: a start accepted at cycle t (phase 0) gives FRAME_STB = 1 and FRAME_SOP = 1 at t+SER_RATIO+1.
//  - FRAME_SOP is 0 on all other frames, including idle frames.
//  Boundary cases
//  - Release and refill of the same bank in one cycle: the clear takes effect first, so IN_READY for that bank rises the next cycle. No overwrite of unread data is possible.
//  - Write completes on one bank while the other is released: the two flags are independent and both updates apply.
//  - RESET mid-packet: partial packets are discarded, and the partial frame is never emitted.
//  - Both banks full: IN_READY = 0 until the read side releases a bank.
// CONFIGURATION
//  DTC_FE_IDLE_PRBS_EN
//  - Defined: idle nibbles come from a per-channel PRBS7 LFSR (x^7+x^6+1).
//    - Channel c is seeded with 7'h7F ^ c; the LFSR advances only in IDLE.
//    - Nibble = lfsr[3:0].
//  - Undefined: idle nibbles are 4'h0 and no LFSR is synthesised.
// STRUCTURE
//  - Package dtc_fe_pkg: SLOT = SER_RATIO*NIB_W+L1_W; IDLE_NIB = 4'h0; PRBS7 seed/taps; read-FSM state encoding (IDLE=1'b0, SEND=1'b1).
//  - Sub-module dtc_fe_pp_bank: two-bank memory plus full flags and wr/rd bank selection.
//    - The framer keeps the phase counter, read FSM, shifters, output register and drop counter.
// TESTING
//  1. Reset, then push 64 cycles of IN_DATA = {ch1 = k[3:0], ch0 = ~k[3:0]}.
//     -> 8 frames; first frame ch0 slot = 32'hFEDCBA98, L1 byte = 0; FRAME_SOP on first only.
//  2. Push 128 nibbles continuously.
//     -> IN_READY stays 1 and 16 consecutive FRAME_STB with data, no idle frame between the packets.
//  3. Hold IN_VALID = 1 after filling both banks (128 nibbles) with the read side still in the first packet.
//     -> IN_READY = 0; STAT_DROP counts each stalled cycle; no data corruption in frames.
//  4. Pulse RESET after 30 nibbles of a packet.
//     -> all outputs 0, IN_READY = 1 the cycle after release, no frame emitted from partial data.
//  5. No input for 3 words: frames are all-zero payload with FRAME_SOP = 0.
//     - With DTC_FE_IDLE_PRBS_EN: ch0 nibbles follow PRBS7 seeded 7'h7F.
//  6. Single packet submitted mid-word (phase 3).
//     -> transmission starts at the next phase 0; FRAME_SOP latency = SER_RATIO+1 from that start.

Source files
------------

// File: rtl/dtc_fe_pkg.sv
// Shared constants, read-FSM encoding and PRBS7 helper for the DTC front-end ping-pong framer.
package dtc_fe_pkg;

    localparam int N_CH_DEF      = 2;
    localparam int NIB_W_DEF     = 4;
    localparam int PKT_LEN_DEF   = 64;
    localparam int SER_RATIO_DEF = 8;
    localparam int L1_W_DEF      = 8;
    localparam int SLOT          = SER_RATIO_DEF * NIB_W_DEF + L1_W_DEF;

    localparam logic [3:0] IDLE_NIB     = 4'h0;
    localparam logic [6:0] PRBS7_SEED   = 7'h7F;
    localparam int         PRBS7_TAP_HI = 6;
    localparam int         PRBS7_TAP_LO = 5;

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_SEND = 1'b1
    } rd_state_t;

    function automatic int slot_w(input int ser_ratio, input int nib_w, input int l1_w);
        return ser_ratio * nib_w + l1_w;
    endfunction

    // x^7 + x^6 + 1, shifting towards the MSB
    function automatic logic [6:0] prbs7_next(input logic [6:0] s);
        return {s[5:0], s[PRBS7_TAP_HI] ^ s[PRBS7_TAP_LO]};
    endfunction

endpackage

// File: rtl/dtc_fe_pp_bank.sv
// Two-bank packet store: write side fills one bank while the read side drains the other.
import dtc_fe_pkg::*;

module dtc_fe_pp_bank #(
    parameter int  DATA_W  = 8,
    parameter int  PKT_LEN = 64,
    localparam int PTR_W   = $clog2(PKT_LEN)
) (
    input  logic              CLK320,
    input  logic              RESET,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_ptr,
    input  logic              rd_release,
    output logic              wr_full,
    output logic              rd_full,
    output logic              other_full,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [0:1][0:PKT_LEN-1];
    logic [1:0]        full;
    logic              wr_bank;
    logic              rd_bank;
    logic [PTR_W-1:0]  wr_ptr;
    logic              wr_last;

    assign wr_last    = wr_en && (wr_ptr == PTR_W'(PKT_LEN - 1));
    assign wr_full    = full[wr_bank];
    assign rd_full    = full[rd_bank];
    assign other_full = full[~rd_bank];
    assign rd_data    = mem[rd_bank][rd_ptr];

    // Set and clear never target the same bank: writes need it empty, release needs it full.
    always_ff @(posedge CLK320 or posedge RESET) begin
        if (RESET) begin
            full    <= '0;
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_ptr  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_last ? '0 : wr_ptr + PTR_W'(1);
            if (wr_last)
                wr_bank <= ~wr_bank;
            if (rd_release)
                rd_bank <= ~rd_bank;
            for (int b = 0; b < 2; b++) begin
                if (wr_last && (wr_bank == b[0]))
                    full[b] <= 1'b1;
                else if (rd_release && (rd_bank == b[0]))
                    full[b] <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK320) begin
        if (wr_en)
            mem[wr_bank][wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/dtc_fe_pingpong_framer.sv
// GBT uplink front-end emulator: ping-pong packet buffer, e-port serialiser and 40 MHz frame packer.
// Build option DTC_FE_IDLE_PRBS_EN: idle nibbles from per-channel PRBS7 instead of zero.
import dtc_fe_pkg::*;

module dtc_fe_pingpong_framer #(
    parameter int  N_CH      = N_CH_DEF,
    parameter int  NIB_W     = NIB_W_DEF,
    parameter int  PKT_LEN   = PKT_LEN_DEF,
    parameter int  SER_RATIO = SER_RATIO_DEF,
    parameter int  L1_W      = L1_W_DEF,
    localparam int SLOT_W    = slot_w(SER_RATIO, NIB_W, L1_W)
) (
    input  logic                     CLK320,
    input  logic                     RESET,
    input  logic [N_CH*NIB_W-1:0]    IN_DATA,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    output logic [N_CH*SLOT_W-1:0]   DTC_FE_OUT,
    output logic                     FRAME_STB,
    output logic                     FRAME_SOP,
    output logic [15:0]              STAT_DROP
);

    localparam int WORD_W = SER_RATIO * NIB_W;
    localparam int DATA_W = N_CH * NIB_W;
    localparam int PTR_W  = $clog2(PKT_LEN);
    localparam int PH_W   = (SER_RATIO > 1) ? $clog2(SER_RATIO) : 1;

    rd_state_t         state;
    logic              rdy_en;
    logic              wr_en;
    logic              wr_full;
    logic              rd_full;
    logic              other_full;
    logic              rd_last;
    logic              word_end;
    logic              sop_pend;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PH_W-1:0]   phase;
    logic [DATA_W-1:0] rd_data;
    logic [DATA_W-1:0] idle_nib;
    logic [DATA_W-1:0] cur_nib;
    logic [WORD_W-1:0] shifter [N_CH];

    assign IN_READY = rdy_en && !wr_full;
    assign wr_en    = IN_VALID && IN_READY;
    assign rd_last  = (state == RD_SEND) && (rd_ptr == PTR_W'(PKT_LEN - 1));
    assign word_end = (phase == '0);
    assign cur_nib  = (state == RD_SEND) ? rd_data : idle_nib;

    dtc_fe_pp_bank #(
        .DATA_W  (DATA_W),
        .PKT_LEN (PKT_LEN)
    ) u_bank (
        .CLK320     (CLK320),
        .RESET      (RESET),
        .wr_en      (wr_en),
        .wr_data    (IN_DATA),
        .rd_ptr     (rd_ptr),
        .rd_release (rd_last),
        .wr_full    (wr_full),
        .rd_full    (rd_full),
        .other_full (other_full),
        .rd_data    (rd_data)
    );

`ifdef DTC_FE_IDLE_PRBS_EN
    logic [6:0] lfsr [N_CH];

    always_ff @(posedge CLK320 or posedge RESET) begin
        if (RESET) begin
            for (int c = 0; c < N_CH; c++)
                lfsr[c] <= PRBS7_SEED ^ 7'(c);
        end else if (state == RD_IDLE) begin
            for (int c = 0; c < N_CH; c++)
                lfsr[c] <= prbs7_next(lfsr[c]);
        end
    end

    always_comb begin
        idle_nib = '0;
        for (int c = 0; c < N_CH; c++)
            idle_nib[c*NIB_W +: NIB_W] = NIB_W'(lfsr[c][3:0]);
    end
`else
    assign idle_nib = {N_CH{NIB_W'(IDLE_NIB)}};
`endif

    // A word is the nibbles captured at phases 1..SER_RATIO-1,0; a start seen at phase 0
    // therefore reads its first nibble at phase 1 and frames SER_RATIO+1 cycles later.
    always_ff @(posedge CLK320 or posedge RESET) begin
        if (RESET) begin
            state      <= RD_IDLE;
            rdy_en     <= 1'b0;
            rd_ptr     <= '0;
            phase      <= '0;
            sop_pend   <= 1'b0;
            STAT_DROP  <= '0;
            DTC_FE_OUT <= '0;
            FRAME_STB  <= 1'b0;
            FRAME_SOP  <= 1'b0;
            for (int c = 0; c < N_CH; c++)
                shifter[c] <= '0;
        end else begin
            rdy_en <= 1'b1;
            phase  <= (phase == PH_W'(SER_RATIO - 1)) ? '0 : phase + PH_W'(1);

            if (IN_VALID && !IN_READY && (STAT_DROP != 16'hFFFF))
                STAT_DROP <= STAT_DROP + 16'd1;

            if (word_end)
                sop_pend <= 1'b0;

            case (state)
                RD_IDLE: begin
                    if (word_end && rd_full) begin
                        state    <= RD_SEND;
                        rd_ptr   <= '0;
                        sop_pend <= 1'b1;
                    end
                end
                RD_SEND: begin
                    if (rd_last) begin
                        rd_ptr <= '0;
                        if (other_full)
                            sop_pend <= 1'b1;
                        else
                            state <= RD_IDLE;
                    end else begin
                        rd_ptr <= rd_ptr + PTR_W'(1);
                    end
                end
            endcase

            FRAME_STB <= word_end;
            FRAME_SOP <= word_end && sop_pend;
            for (int c = 0; c < N_CH; c++) begin
                shifter[c] <= {shifter[c][WORD_W-NIB_W-1:0], cur_nib[c*NIB_W +: NIB_W]};
                if (word_end) begin
                    DTC_FE_OUT[c*SLOT_W +: WORD_W]        <= {shifter[c][WORD_W-NIB_W-1:0], cur_nib[c*NIB_W +: NIB_W]};
                    DTC_FE_OUT[c*SLOT_W + WORD_W +: L1_W] <= '0;
                end
            end
        end
    end

endmodule
